fwd_hazard_ctrl: RTL and testbench

//  Parametrised successor to the fixed two-stage forwarding unit.

---
 rtl/hazard_pkg.sv | 17 +
 rtl/fwd_match.sv | 30 +++
 rtl/fwd_hazard_ctrl.sv | 117 +++++++++++
 tb/tb_fwd_hazard_ctrl.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/hazard_pkg.sv
// Shared types and encodings for the forwarding / load-use hazard controller.
package hazard_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    STALL = 1'b1
  } state_e;

  // Select value 0 means the register file; stage k is encoded as k + SEL_STAGE_BASE.
  localparam int SEL_REGFILE    = 0;
  localparam int SEL_STAGE_BASE = 1;

  function automatic int sel_w(input int num_fwd);
    return $clog2(num_fwd + 1);
  endfunction

endpackage

// File: rtl/fwd_match.sv
// Compares one EX-stage source register against every forwarding stage and
// returns the select of the nearest stage that writes it (0 = regfile).
module fwd_match
  import hazard_pkg::*;
#(
  parameter int NUM_FWD = 2,
  parameter int REG_AW  = 5,
  parameter int SEL_W   = 2
) (
  input  logic [NUM_FWD-1:0]        fwd_we_i,
  input  logic [NUM_FWD*REG_AW-1:0] fwd_rd_i,
  input  logic [REG_AW-1:0]         src_i,
  output logic [SEL_W-1:0]          sel_o
);

  // NOTE: every always_comb output gets a default first so no path leaves it
  // unassigned; otherwise synthesis infers a latch.
  always_comb begin
    sel_o = SEL_W'(SEL_REGFILE);
    // Walk farthest to nearest so the nearest match overwrites the others.
    for (int k = NUM_FWD - 1; k >= 0; k--) begin
      if (fwd_we_i[k] &&
          (fwd_rd_i[k*REG_AW +: REG_AW] != '0) &&
          (fwd_rd_i[k*REG_AW +: REG_AW] == src_i)) begin
        sel_o = SEL_W'(k + SEL_STAGE_BASE);
      end
    end
  end

endmodule

// File: rtl/fwd_hazard_ctrl.sv
// Forwarding select generation for NUM_SRC operands plus load-use stall
// control that holds the front end for LOAD_LAT cycles after a load.
module fwd_hazard_ctrl
  import hazard_pkg::*;
#(
  parameter  int NUM_SRC  = 2,
  parameter  int NUM_FWD  = 2,
  parameter  int REG_AW   = 5,
  parameter  int LOAD_LAT = 1,
  localparam int SEL_W    = sel_w(NUM_FWD)
) (
  input  logic                      clk_i,
  input  logic                      rst_n,
  input  logic [NUM_FWD-1:0]        fwd_we_i,
  input  logic [NUM_FWD*REG_AW-1:0] fwd_rd_i,
  input  logic [NUM_SRC*REG_AW-1:0] ex_src_i,
  output logic [NUM_SRC*SEL_W-1:0]  fwd_sel_o,
  input  logic                      idex_mem_read_i,
  input  logic [REG_AW-1:0]         idex_rd_i,
  input  logic [NUM_SRC*REG_AW-1:0] id_src_i,
  input  logic [NUM_SRC-1:0]        id_src_used_i,
  input  logic                      hold_i,
  input  logic                      flush_i,
  output logic                      stall_o,
  output logic                      pc_write_o,
  output logic                      ifid_write_o,
  output logic                      idex_bubble_o,
  output logic [31:0]               stall_cycles_o
);

  localparam int CNT_W = $clog2(LOAD_LAT + 1);

  state_e             r_state;
  logic [CNT_W-1:0]   r_cnt;
  logic [31:0]        r_stall_cycles;
  logic               w_src_hit;
  logic               w_det;
  logic               w_stall;

  for (genvar i = 0; i < NUM_SRC; i++) begin : g_fwd
    fwd_match #(
      .NUM_FWD (NUM_FWD),
      .REG_AW  (REG_AW),
      .SEL_W   (SEL_W)
    ) u_fwd_match (
      .fwd_we_i (fwd_we_i),
      .fwd_rd_i (fwd_rd_i),
      .src_i    (ex_src_i[i*REG_AW +: REG_AW]),
      .sel_o    (fwd_sel_o[i*SEL_W +: SEL_W])
    );
  end

  always_comb begin
    w_src_hit = 1'b0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (id_src_used_i[i] && (id_src_i[i*REG_AW +: REG_AW] == idex_rd_i)) begin
        w_src_hit = 1'b1;
      end
    end
  end

  // A flushed or frozen ID stage cannot raise a hazard, nor can one in reset.
  assign w_det = idex_mem_read_i && (idex_rd_i != '0) && w_src_hit &&
                 !flush_i && !hold_i && rst_n;

  always_comb begin
    w_stall = w_det;
    if (r_state == STALL) w_stall = !flush_i;
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          // A single-cycle latency is covered by the bubble issued in IDLE.
          if (w_det && (LOAD_LAT > 1)) begin
            r_state <= STALL;
            r_cnt   <= CNT_W'(LOAD_LAT - 1);
          end
        end
        STALL: begin
          if (flush_i) begin
            r_state <= IDLE;
            r_cnt   <= '0;
          end else if (!hold_i) begin
            if (r_cnt == CNT_W'(1)) r_state <= IDLE;
            r_cnt <= r_cnt - CNT_W'(1);
          end
        end
        default: begin
          r_state <= IDLE;
          r_cnt   <= '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      r_stall_cycles <= '0;
    end else if (w_stall && !hold_i && (r_stall_cycles != 32'hFFFF_FFFF)) begin
      r_stall_cycles <= r_stall_cycles + 32'd1;
    end
  end

  assign stall_o        = w_stall;
  assign pc_write_o     = !w_stall;
  assign ifid_write_o   = !w_stall;
  assign idex_bubble_o  = w_stall;
  assign stall_cycles_o = r_stall_cycles;

endmodule

// File: tb/tb_fwd_hazard_ctrl.sv
// Directed bench for fwd_hazard_ctrl: one instance with LOAD_LAT=1 and one
// with LOAD_LAT=3 share all inputs; each task checks the instance it targets.
module tb_fwd_hazard_ctrl;

  logic        clk;
  logic        rst_n;
  logic [1:0]  fwd_we;
  logic [9:0]  fwd_rd;
  logic [9:0]  ex_src;
  logic        idex_mem_read;
  logic [4:0]  idex_rd;
  logic [9:0]  id_src;
  logic [1:0]  id_src_used;
  logic        hold;
  logic        flush;

  logic [3:0]  sel1,   sel3;
  logic        stall1, stall3;
  logic        pcw1,   pcw3;
  logic        ifid1,  ifid3;
  logic        bub1,   bub3;
  logic [31:0] cyc1,   cyc3;

  int n_pass  = 0;
  int n_total = 0;

  fwd_hazard_ctrl #(.NUM_SRC(2), .NUM_FWD(2), .REG_AW(5), .LOAD_LAT(1)) dut1 (
    .clk_i(clk), .rst_n(rst_n),
    .fwd_we_i(fwd_we), .fwd_rd_i(fwd_rd), .ex_src_i(ex_src), .fwd_sel_o(sel1),
    .idex_mem_read_i(idex_mem_read), .idex_rd_i(idex_rd),
    .id_src_i(id_src), .id_src_used_i(id_src_used),
    .hold_i(hold), .flush_i(flush),
    .stall_o(stall1), .pc_write_o(pcw1), .ifid_write_o(ifid1),
    .idex_bubble_o(bub1), .stall_cycles_o(cyc1)
  );

  fwd_hazard_ctrl #(.NUM_SRC(2), .NUM_FWD(2), .REG_AW(5), .LOAD_LAT(3)) dut3 (
    .clk_i(clk), .rst_n(rst_n),
    .fwd_we_i(fwd_we), .fwd_rd_i(fwd_rd), .ex_src_i(ex_src), .fwd_sel_o(sel3),
    .idex_mem_read_i(idex_mem_read), .idex_rd_i(idex_rd),
    .id_src_i(id_src), .id_src_used_i(id_src_used),
    .hold_i(hold), .flush_i(flush),
    .stall_o(stall3), .pc_write_o(pcw3), .ifid_write_o(ifid3),
    .idex_bubble_o(bub3), .stall_cycles_o(cyc3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic clear_inputs();
    fwd_we        = '0;
    fwd_rd        = '0;
    ex_src        = '0;
    idex_mem_read = 1'b0;
    idex_rd       = '0;
    id_src        = '0;
    id_src_used   = '0;
    hold          = 1'b0;
    flush         = 1'b0;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst_n = 1'b0;
    clear_inputs();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Load in ID/EX writing r4, ID operand 0 reads r4.
  task automatic drive_load_use(input logic [1:0] used);
    idex_mem_read = 1'b1;
    idex_rd       = 5'd4;
    id_src        = {5'd7, 5'd4};
    id_src_used   = used;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    clear_inputs();
    drive_load_use(2'b01);
    #3;
    n_total++;
    if (stall1 !== 1'b0) $display("FAIL reset_stall1: got %b expected 0", stall1); else n_pass++;
    n_total++;
    if (stall3 !== 1'b0) $display("FAIL reset_stall3: got %b expected 0", stall3); else n_pass++;
    n_total++;
    if ({pcw1, ifid1, bub1} !== 3'b110)
      $display("FAIL reset_ctrl1: got %b expected 110", {pcw1, ifid1, bub1});
    else n_pass++;
    n_total++;
    if (cyc3 !== 32'd0) $display("FAIL reset_cycles3: got %h expected 0", cyc3); else n_pass++;
    @(negedge clk);
    rst_n = 1'b1;
    clear_inputs();
  endtask

  task automatic test_fwd_nearest();
    @(negedge clk);
    fwd_we = 2'b11;
    fwd_rd = {5'd8, 5'd8};
    ex_src = {5'd9, 5'd8};
    #1;
    n_total++;
    if (sel1 !== 4'b0001) $display("FAIL fwd_nearest: got %b expected 0001", sel1); else n_pass++;
    ex_src = {5'd8, 5'd8};
    fwd_we = 2'b10;
    #1;
    n_total++;
    if (sel3 !== 4'b1010) $display("FAIL fwd_far_only: got %b expected 1010", sel3); else n_pass++;
  endtask

  task automatic test_fwd_r0();
    @(negedge clk);
    fwd_we = 2'b11;
    fwd_rd = {5'd3, 5'd0};
    ex_src = {5'd3, 5'd0};
    #1;
    n_total++;
    if (sel1 !== 4'b1000) $display("FAIL fwd_r0: got %b expected 1000", sel1); else n_pass++;
    fwd_we = 2'b01;
    ex_src = {5'd3, 5'd3};
    #1;
    n_total++;
    if (sel1 !== 4'b0000) $display("FAIL fwd_we_off: got %b expected 0000", sel1); else n_pass++;
    clear_inputs();
  endtask

  task automatic test_load_use_lat1();
    apply_reset();
    @(negedge clk);
    drive_load_use(2'b01);
    #1;
    n_total++;
    if ({stall1, pcw1, ifid1, bub1} !== 4'b1001)
      $display("FAIL lat1_stall: got %b expected 1001", {stall1, pcw1, ifid1, bub1});
    else n_pass++;
    @(negedge clk);
    idex_mem_read = 1'b0;
    #1;
    n_total++;
    if (stall1 !== 1'b0) $display("FAIL lat1_release: got %b expected 0", stall1); else n_pass++;
    @(negedge clk);
    drive_load_use(2'b10);
    #1;
    n_total++;
    if (stall1 !== 1'b0) $display("FAIL lat1_unused: got %b expected 0", stall1); else n_pass++;
    n_total++;
    if (cyc1 !== 32'd1) $display("FAIL lat1_cycles: got %0d expected 1", cyc1); else n_pass++;
    clear_inputs();
  endtask

  task automatic test_lat3_hold();
    logic [4:0] seen;
    logic [4:0] want;
    want = 5'b01111;
    apply_reset();
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      clear_inputs();
      if (c == 0) drive_load_use(2'b01);
      if (c == 1) hold = 1'b1;
      #1;
      seen[c] = stall3;
    end
    n_total++;
    if (seen !== want) $display("FAIL lat3_hold_trace: got %b expected %b", seen, want); else n_pass++;
    n_total++;
    if (cyc3 !== 32'd3) $display("FAIL lat3_cycles: got %0d expected 3", cyc3); else n_pass++;
  endtask

  task automatic test_flush_and_reset();
    apply_reset();
    @(negedge clk);
    drive_load_use(2'b01);
    @(negedge clk);
    clear_inputs();
    flush = 1'b1;
    #1;
    n_total++;
    if (stall3 !== 1'b0) $display("FAIL flush_stall: got %b expected 0", stall3); else n_pass++;
    @(negedge clk);
    flush = 1'b0;
    #1;
    n_total++;
    if (stall3 !== 1'b0) $display("FAIL flush_idle: got %b expected 0", stall3); else n_pass++;
    @(negedge clk);
    drive_load_use(2'b01);
    @(negedge clk);
    clear_inputs();
    #1;
    n_total++;
    if (stall3 !== 1'b1) $display("FAIL mid_stall: got %b expected 1", stall3); else n_pass++;
    #1;
    rst_n = 1'b0;
    #1;
    n_total++;
    if ({stall3, pcw3, ifid3, bub3} !== 4'b0110)
      $display("FAIL reset_mid_stall: got %b expected 0110", {stall3, pcw3, ifid3, bub3});
    else n_pass++;
    n_total++;
    if (cyc3 !== 32'd0) $display("FAIL reset_mid_cycles: got %0d expected 0", cyc3); else n_pass++;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    n_total++;
    if (stall3 !== 1'b0) $display("FAIL after_reset: got %b expected 0", stall3); else n_pass++;
  endtask

  task automatic test_saturate();
    apply_reset();
    @(negedge clk);
    force dut3.r_stall_cycles = 32'hFFFF_FFFE;
    #1;
    release dut3.r_stall_cycles;
    drive_load_use(2'b01);
    @(negedge clk);
    clear_inputs();
    #1;
    n_total++;
    if (cyc3 !== 32'hFFFF_FFFF) $display("FAIL sat_step: got %h expected ffffffff", cyc3); else n_pass++;
    @(negedge clk);
    @(negedge clk);
    #1;
    n_total++;
    if (stall3 !== 1'b0) $display("FAIL sat_stall_end: got %b expected 0", stall3); else n_pass++;
    n_total++;
    if (cyc3 !== 32'hFFFF_FFFF) $display("FAIL sat_hold: got %h expected ffffffff", cyc3); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_fwd_nearest();
    test_fwd_r0();
    test_load_use_lat1();
    test_lat3_hold();
    test_flush_and_reset();
    test_saturate();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
